// File: rtl/pygmy_pkg.sv
// rtl/pygmy_pkg.sv - shared decode constants, ALU opcode encoding and control bundle type
// Contents:
//   alu_op_e          ALU operation encoding, shared with the execute-stage ALU
//   OPC_*             RV32I major opcodes accepted by decode
//   MEM_HB_*          memory access size encoding on mem_hb
//   FUNCT7_*          funct7 values that qualify OP / shift-immediate forms
//   ctrl_t            control half of the ID/EX bundle
//   ctrl_bubble()     control bundle of a pipeline bubble
//   alu_op_from_funct3()  funct3 (+ alternate bit) to ALU operation

package pygmy_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] MEM_HB_BYTE = 2'b00;
    localparam logic [1:0] MEM_HB_HALF = 2'b01;
    localparam logic [1:0] MEM_HB_WORD = 2'b10;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e    alu_opcode;
        logic       alu_src;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic [1:0] mem_hb;
        logic       mem_ul;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c.alu_opcode = ALU_ADD;
        c.alu_src    = 1'b0;
        c.reg_we     = 1'b0;
        c.mem_we     = 1'b0;
        c.mem_re     = 1'b0;
        c.mem_hb     = 2'b00;
        c.mem_ul     = 1'b0;
        c.illegal    = 1'b0;
        return c;
    endfunction

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers only
    // set it for encodings where funct7[5] is meaningful.
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - architectural register file, 2 read / 1 write, x0 hardwired, write-to-read bypass
// Ports:
//   clk_i                 clock (no reset: contents survive pipeline reset)
//   we_i, wptr_i, wdata_i write port; writes to x0 are dropped
//   rptr_a_i, rptr_b_i    combinational read indices
//   rdata_a_o, rdata_b_o  read data; 0 for x0, wdata_i when the same-cycle write targets the index

module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [4:0]      wptr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      rptr_a_i,
    input  logic [4:0]      rptr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] mem [NREGS];
    logic            write_live;

    // A write is only architecturally visible when it targets a real register.
    assign write_live = we_i && (wptr_i != 5'd0);

    always_ff @(posedge clk_i) begin
        if (write_live) begin
            mem[wptr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = mem[rptr_a_i];
        if (rptr_a_i == 5'd0) begin
            rdata_a_o = '0;
        end else if (write_live && (wptr_i == rptr_a_i)) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = mem[rptr_b_i];
        if (rptr_b_i == 5'd0) begin
            rdata_b_o = '0;
        end else if (write_live && (wptr_i == rptr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode, register file and ID/EX pipeline register
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset (ID/EX only)
//   instr_i, instr_valid_i       fetched instruction and its qualifier
//   stall_i, flush_i             hold / bubble the ID/EX register (flush wins)
//   wb_data_i, wb_ptr_i, wb_we_i writeback from execute into the register file
//   rd_ptr_o, rs1_o, rs2_o, imm_o  registered operands
//   alu_opcode_o, alu_src_o, reg_we_o, mem_we_o, mem_re_o, mem_hb_o, mem_ul_o, illegal_o
//                                registered control bundle

module decode_stage
    import pygmy_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [4:0]      wb_ptr_i,
    input  logic            wb_we_i,
    output logic [4:0]      rd_ptr_o,
    output logic [XLEN-1:0] rs1_o,
    output logic [XLEN-1:0] rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [3:0]      alu_opcode_o,
    output logic            alu_src_o,
    output logic            reg_we_o,
    output logic            mem_we_o,
    output logic            mem_re_o,
    output logic [1:0]      mem_hb_o,
    output logic            mem_ul_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [4:0] rd_idx;
    logic [2:0] funct3;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [6:0] funct7;

    assign opcode  = instr_i[6:0];
    assign rd_idx  = instr_i[11:7];
    assign funct3  = instr_i[14:12];
    assign rs1_idx = instr_i[19:15];
    assign rs2_idx = instr_i[24:20];
    assign funct7  = instr_i[31:25];

    logic [XLEN-1:0] rf_rdata_a;
    logic [XLEN-1:0] rf_rdata_b;

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i     (clk_i),
        .we_i      (wb_we_i),
        .wptr_i    (wb_ptr_i),
        .wdata_i   (wb_data_i),
        .rptr_a_i  (rs1_idx),
        .rptr_b_i  (rs2_idx),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    logic [31:0] imm_i_type;
    logic [31:0] imm_s_type;
    logic [31:0] imm_u_type;
    logic [31:0] imm_shamt;

    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u_type = {instr_i[31:12], 12'b0};
    assign imm_shamt  = {27'b0, instr_i[24:20]};

    ctrl_t       dec_ctrl;
    logic [31:0] dec_imm32;
    logic        dec_illegal;
    logic        dec_rs1_zero;

    always_comb begin
        dec_ctrl     = ctrl_bubble();
        dec_imm32    = '0;
        dec_illegal  = 1'b0;
        dec_rs1_zero = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                dec_ctrl.reg_we = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    dec_ctrl.alu_opcode = alu_op_from_funct3(funct3, 1'b0);
                end else if ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    dec_ctrl.alu_opcode = alu_op_from_funct3(funct3, 1'b1);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_imm32        = imm_i_type;
                if (funct3 == 3'b001) begin
                    // Shift-immediates carry funct7 in the upper immediate bits.
                    dec_imm32           = imm_shamt;
                    dec_ctrl.alu_opcode = ALU_SLL;
                    dec_illegal         = (funct7 != FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_imm32 = imm_shamt;
                    if (funct7 == FUNCT7_BASE) begin
                        dec_ctrl.alu_opcode = ALU_SRL;
                    end else if (funct7 == FUNCT7_ALT) begin
                        dec_ctrl.alu_opcode = ALU_SRA;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    // funct3=000 is always ADDI here: there is no SUBI.
                    dec_ctrl.alu_opcode = alu_op_from_funct3(funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_ctrl.mem_re  = 1'b1;
                dec_ctrl.mem_ul  = funct3[2];
                dec_imm32        = imm_i_type;
                unique case (funct3[1:0])
                    2'b00:   dec_ctrl.mem_hb = MEM_HB_BYTE;
                    2'b01:   dec_ctrl.mem_hb = MEM_HB_HALF;
                    2'b10: begin
                        dec_ctrl.mem_hb = MEM_HB_WORD;
                        // No unsigned word load on RV32.
                        dec_illegal     = funct3[2];
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.mem_we  = 1'b1;
                dec_imm32        = imm_s_type;
                dec_illegal      = funct3[2];
                unique case (funct3[1:0])
                    2'b00:   dec_ctrl.mem_hb = MEM_HB_BYTE;
                    2'b01:   dec_ctrl.mem_hb = MEM_HB_HALF;
                    2'b10:   dec_ctrl.mem_hb = MEM_HB_WORD;
                    default: dec_illegal     = 1'b1;
                endcase
            end
            OPC_LUI: begin
                // Executed as 0 + imm so the ALU needs no pass-through op.
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_imm32        = imm_u_type;
                dec_rs1_zero     = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (rd_idx == 5'd0) begin
            dec_ctrl.reg_we = 1'b0;
        end

        if (dec_illegal) begin
            dec_ctrl         = ctrl_bubble();
            dec_ctrl.illegal = 1'b1;
            dec_imm32        = '0;
        end
    end

    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_rs1;
    logic [XLEN-1:0] dec_rs2;
    logic [XLEN-1:0] dec_imm;

    assign dec_rd  = dec_illegal ? 5'd0 : rd_idx;
    assign dec_rs1 = (dec_illegal || dec_rs1_zero) ? '0 : rf_rdata_a;
    assign dec_rs2 = dec_illegal ? '0 : rf_rdata_b;
    assign dec_imm = XLEN'($signed(dec_imm32));

    ctrl_t           q_ctrl;
    logic [4:0]      q_rd;
    logic [XLEN-1:0] q_rs1;
    logic [XLEN-1:0] q_rs2;
    logic [XLEN-1:0] q_imm;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            q_ctrl <= ctrl_bubble();
            q_rd   <= '0;
            q_rs1  <= '0;
            q_rs2  <= '0;
            q_imm  <= '0;
        end else if (stall_i) begin
            q_ctrl <= q_ctrl;
            q_rd   <= q_rd;
            q_rs1  <= q_rs1;
            q_rs2  <= q_rs2;
            q_imm  <= q_imm;
        end else if (!instr_valid_i) begin
            q_ctrl <= ctrl_bubble();
            q_rd   <= '0;
            q_rs1  <= '0;
            q_rs2  <= '0;
            q_imm  <= '0;
        end else begin
            q_ctrl <= dec_ctrl;
            q_rd   <= dec_rd;
            q_rs1  <= dec_rs1;
            q_rs2  <= dec_rs2;
            q_imm  <= dec_imm;
        end
    end

    assign rd_ptr_o     = q_rd;
    assign rs1_o        = q_rs1;
    assign rs2_o        = q_rs2;
    assign imm_o        = q_imm;
    assign alu_opcode_o = q_ctrl.alu_opcode;
    assign alu_src_o    = q_ctrl.alu_src;
    assign reg_we_o     = q_ctrl.reg_we;
    assign mem_we_o     = q_ctrl.mem_we;
    assign mem_re_o     = q_ctrl.mem_re;
    assign mem_hb_o     = q_ctrl.mem_hb;
    assign mem_ul_o     = q_ctrl.mem_ul;
    assign illegal_o    = q_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a mnemonic-level reference model

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] wb_data_i;
    logic [4:0]  wb_ptr_i;
    logic        wb_we_i;
    logic [4:0]  rd_ptr_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_opcode_o;
    logic        alu_src_o;
    logic        reg_we_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [1:0]  mem_hb_o;
    logic        mem_ul_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .wb_data_i     (wb_data_i),
        .wb_ptr_i      (wb_ptr_i),
        .wb_we_i       (wb_we_i),
        .rd_ptr_o      (rd_ptr_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .imm_o         (imm_o),
        .alu_opcode_o  (alu_opcode_o),
        .alu_src_o     (alu_src_o),
        .reg_we_o      (reg_we_o),
        .mem_we_o      (mem_we_o),
        .mem_re_o      (mem_re_o),
        .mem_hb_o      (mem_hb_o),
        .mem_ul_o      (mem_ul_o),
        .illegal_o     (illegal_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        src;
        logic        we;
        logic        mwe;
        logic        mre;
        logic [1:0]  hb;
        logic        ul;
        logic        ill;
    } bundle_t;

    // Mnemonic tables: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
    localparam logic [2:0] R_F3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam logic       R_ALT [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [3:0] R_OP  [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    // ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
    localparam logic [2:0] I_F3  [9]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
    localparam logic [3:0] I_OP  [9]  = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd7};
    // JAL JALR BRANCH AUIPC SYSTEM FENCE: none supported by this stage
    localparam logic [6:0] BAD_OPC [6] = '{7'h6f, 7'h67, 7'h63, 7'h17, 7'h73, 7'h0f};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] regs [32];
    bundle_t     cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t bubble();
        bundle_t b;
        b.rd = '0; b.rs1 = '0; b.rs2 = '0; b.imm = '0; b.op = '0;
        b.src = 1'b0; b.we = 1'b0; b.mwe = 1'b0; b.mre = 1'b0;
        b.hb = '0; b.ul = 1'b0; b.ill = 1'b0;
        return b;
    endfunction

    function automatic bundle_t illegal_bundle();
        bundle_t b;
        b = bubble();
        b.ill = 1'b1;
        return b;
    endfunction

    function automatic bundle_t mk(input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                                   input logic src, input logic we, input logic mwe, input logic mre,
                                   input logic [1:0] hb, input logic ul);
        bundle_t b;
        b = bubble();
        b.rd = rd; b.imm = imm; b.op = op; b.src = src; b.we = we;
        b.mwe = mwe; b.mre = mre; b.hb = hb; b.ul = ul;
        return b;
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wwe,
                                               input logic [4:0] wptr, input logic [31:0] wdat);
        if (idx == 5'd0) return 32'd0;
        if (wwe && wptr != 5'd0 && wptr == idx) return wdat;
        return regs[idx];
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, ".rd"},      {27'b0, rd_ptr_o},     {27'b0, cur.rd});
        check({tag, ".rs1"},     rs1_o,                 cur.rs1);
        check({tag, ".rs2"},     rs2_o,                 cur.rs2);
        check({tag, ".imm"},     imm_o,                 cur.imm);
        check({tag, ".aluop"},   {28'b0, alu_opcode_o}, {28'b0, cur.op});
        check({tag, ".alusrc"},  {31'b0, alu_src_o},    {31'b0, cur.src});
        check({tag, ".regwe"},   {31'b0, reg_we_o},     {31'b0, cur.we});
        check({tag, ".memwe"},   {31'b0, mem_we_o},     {31'b0, cur.mwe});
        check({tag, ".memre"},   {31'b0, mem_re_o},     {31'b0, cur.mre});
        check({tag, ".memhb"},   {30'b0, mem_hb_o},     {30'b0, cur.hb});
        check({tag, ".memul"},   {31'b0, mem_ul_o},     {31'b0, cur.ul});
        check({tag, ".illegal"}, {31'b0, illegal_o},    {31'b0, cur.ill});
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic [31:0] ins, input logic vld, input logic stl, input logic fl,
                        input logic rs, input logic wwe, input logic [4:0] wptr, input logic [31:0] wdat,
                        input bundle_t dec, input logic rs1z, input string tag);
        bundle_t nxt;
        instr_i = ins; instr_valid_i = vld; stall_i = stl; flush_i = fl; rst_i = rs;
        wb_we_i = wwe; wb_ptr_i = wptr; wb_data_i = wdat;
        if (rs || fl) nxt = bubble();
        else if (stl) nxt = cur;
        else if (!vld) nxt = bubble();
        else if (dec.ill) nxt = illegal_bundle();
        else begin
            nxt = dec;
            nxt.rs1 = rs1z ? 32'd0 : model_read(ins[19:15], wwe, wptr, wdat);
            nxt.rs2 = model_read(ins[24:20], wwe, wptr, wdat);
        end
        @(posedge clk);
        if (wwe && wptr != 5'd0) regs[wptr] = wdat;
        cur = nxt;
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, bubble(), 1'b0, tag);
    endtask

    task automatic gen(output logic [31:0] ins, output bundle_t dec, output logic rs1z);
        logic [4:0]  rd, r1, r2, sh;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [2:0]  f3;
        int          k, j;
        rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); sh = 5'($urandom);
        i12 = 12'($urandom); u20 = 20'($urandom); f3 = 3'($urandom);
        rs1z = 1'b0;
        k = $urandom_range(0, 9);
        if (k <= 2) begin
            j = $urandom_range(0, 9);
            ins = {R_ALT[j] ? 7'h20 : 7'h00, r2, r1, R_F3[j], rd, 7'h33};
            dec = mk(rd, 32'd0, R_OP[j], 1'b0, rd != 0, 1'b0, 1'b0, 2'b00, 1'b0);
        end else if (k <= 4) begin
            j = $urandom_range(0, 8);
            if (j >= 6) begin
                ins = {(j == 8) ? 7'h20 : 7'h00, sh, r1, I_F3[j], rd, 7'h13};
                dec = mk(rd, {27'b0, sh}, I_OP[j], 1'b1, rd != 0, 1'b0, 1'b0, 2'b00, 1'b0);
            end else begin
                ins = {i12, r1, I_F3[j], rd, 7'h13};
                dec = mk(rd, sext12(i12), I_OP[j], 1'b1, rd != 0, 1'b0, 1'b0, 2'b00, 1'b0);
            end
        end else if (k == 5) begin
            ins = {i12, r1, f3, rd, 7'h03};
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec = illegal_bundle();
            else dec = mk(rd, sext12(i12), 4'd0, 1'b1, rd != 0, 1'b0, 1'b1, f3[1:0], f3[2]);
        end else if (k == 6) begin
            ins = {i12[11:5], r2, r1, f3, i12[4:0], 7'h23};
            if (f3 > 3'd2) dec = illegal_bundle();
            else dec = mk(i12[4:0], sext12(i12), 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, f3[1:0], 1'b0);
        end else if (k == 7) begin
            ins = {u20, rd, 7'h37};
            dec = mk(rd, {u20, 12'b0}, 4'd0, 1'b1, rd != 0, 1'b0, 1'b0, 2'b00, 1'b0);
            rs1z = 1'b1;
        end else begin
            j = $urandom_range(0, 6);
            if (j == 6) ins = {7'h01, r2, r1, f3, rd, 7'h33};
            else        ins = {25'($urandom), BAD_OPC[j]};
            dec = illegal_bundle();
        end
    endtask

    initial begin
        logic [31:0] ins;
        bundle_t     dec;
        logic        rs1z;
        logic        wwe;

        cur = bubble();
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, bubble(), 1'b0, "reset");
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, bubble(), 1'b0, "reset");
        for (int i = 0; i < 3; i++) idle("idle");

        // Fill every register so later reads have a defined model value.
        for (int r = 1; r < 32; r++)
            step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(r), $urandom, bubble(), 1'b0, "fill");

        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, bubble(), 1'b0, "wr_x5");
        step(32'h005281B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd3, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "add");
        check("add_rs1", rs1_o, 32'h0000_1234);
        check("add_rs2", rs2_o, 32'h0000_1234);
        check("add_rd", {27'b0, rd_ptr_o}, 32'd3);

        step(32'hFFF30393, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF,
             mk(5'd7, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "bypass");
        check("bypass_rs1", rs1_o, 32'hDEAD_BEEF);
        check("bypass_imm", imm_o, 32'hFFFF_FFFF);

        step(32'hFFF00393, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF,
             mk(5'd7, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "bypass_x0");
        check("bypass_x0_rs1", rs1_o, 32'd0);

        step(32'h00415083, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd1, 32'd4, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1), 1'b0, "lhu");
        check("lhu_hb", {30'b0, mem_hb_o}, 32'd1);

        step(32'hFE310C23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd24, 32'hFFFF_FFF8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0), 1'b0, "sb");
        check("sb_imm", imm_o, 32'hFFFF_FFF8);

        step(32'h00013083, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, illegal_bundle(), 1'b0, "ld_f3_011");
        check("ld_f3_011_illegal", {31'b0, illegal_o}, 32'd1);

        step(32'h005281B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd3, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "pre_stall");
        for (int i = 0; i < 2; i++) begin
            gen(ins, dec, rs1z);
            step(ins, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, dec, rs1z, "stall");
        end
        check("stall_rs1", rs1_o, 32'h0000_1234);
        gen(ins, dec, rs1z);
        step(ins, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, dec, rs1z, "flush_stall");
        check("flush_stall_regwe", {31'b0, reg_we_o}, 32'd0);

        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55, bubble(), 1'b0, "wr_x0");
        step(32'h000001B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd3, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "rd_x0");
        check("rd_x0_rs1", rs1_o, 32'd0);

        step(32'h005281B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd3, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "pre_rst");
        step(32'h005281B3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hCAFE_0009, bubble(), 1'b0, "mid_rst");
        check("mid_rst_rs1", rs1_o, 32'd0);
        step(32'h009281B3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(5'd3, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, "post_rst");
        check("post_rst_rs1", rs1_o, 32'h0000_1234);
        check("post_rst_rs2", rs2_o, 32'hCAFE_0009);

        for (int n = 0; n < 1500; n++) begin
            gen(ins, dec, rs1z);
            wwe = 1'($urandom);
            step(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 63) == 0, wwe, 5'($urandom), $urandom, dec, rs1z, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage plus architectural register file and ID/EX pipeline register.
- Sits directly upstream of the execute stage. Consumes a fetched 32-bit RV32I instruction and produces the registered operand and control bundle that execute consumes.
- Also accepts execute's writeback triple (data, pointer, write enable) into the register file, with same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- instr_i  in  32  fetched instruction
- instr_valid_i  in  1  instr_i is valid this cycle
- stall_i  in  1  hold the ID/EX register
- flush_i  in  1  load a bubble into the ID/EX register
- wb_data_i  in  32  writeback data (execute rd_o)
- wb_ptr_i  in  5  writeback register (execute rd_ptr_o)
- wb_we_i  in  1  writeback enable (execute reg_we_o)
- rd_ptr_o  out  5  destination register
- rs1_o  out  32  operand 1
- rs2_o  out  32  operand 2 / store data
- imm_o  out  32  sign-extended immediate
- alu_opcode_o  out  4  ALU operation (package encoding)
- alu_src_o  out  1  1 selects imm_o as ALU operand 2
- reg_we_o  out  1  writeback enable
- mem_we_o  out  1  store
- mem_re_o  out  1  load
- mem_hb_o  out  2  size: 00 byte, 01 half, 10 word
- mem_ul_o  out  1  unsigned load (funct3[2])
- illegal_o  out  1  unsupported or invalid instruction was latched

Behaviour:
- Register file: NREGS x XLEN, written on the rising edge when wb_we_i=1 and wb_ptr_i!=0; writes to x0 are ignored. Two combinational read ports indexed by instr_i[19:15] and instr_i[24:20]. Register file is NOT cleared by reset.
- Read rules:
  - Index 0 always reads 0.
  - Bypass: when wb_we_i=1, wb_ptr_i!=0 and wb_ptr_i equals the read index, the read returns wb_data_i.
- Decode, combinational; anything not listed is unsupported:
  - OP (0110011): alu_src=0; funct3/funct7[5] map to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM (0010011): alu_src=1, I-immediate. SLLI/SRLI/SRAI use shamt = imm[4:0]; funct7[5] selects SRA.
  - LOAD (0000011): ADD, alu_src=1, I-immediate, mem_re=1, reg_we=1. Size from funct3[1:0]; mem_ul=funct3[2]. funct3 of 011, 110 or 111 is illegal.
  - STORE (0100011): ADD, alu_src=1, S-immediate, mem_we=1, reg_we=0. funct3 above 010 is illegal.
  - LUI (0110111): rs1 forced to 0, U-immediate (imm[31:12], low 12 bits zero), ADD, alu_src=1, reg_we=1.
  - reg_we is forced to 0 when rd=0.
- Illegal instruction: output is a bubble with illegal_o=1.
- Bubble: all control outputs (reg_we, mem_we, mem_re, alu_src, illegal) = 0, alu_opcode=ADD; data outputs are 0.
- ID/EX register update, priority order:
  1. rst_i: bubble, all outputs 0.
  2. flush_i: bubble.
  3. stall_i: hold all outputs.
  4. instr_valid_i=0: bubble.
  5. Otherwise: load the decoded bundle.
- Latency: one cycle from instr_i to outputs.
- Writeback port is honoured during stall, flush and reset cycles (reset does not block the write).
- Reset mid-operation discards the in-flight instruction. Register contents survive reset.

Decomposition:
- Package pygmy_pkg:
  - ALU opcode constants: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9 (shared with the ALU).
  - RV32I opcode constants.
  - mem_hb constants.
- Sub-module regfile: 2 read ports, 1 write port, x0 and bypass logic.
- Decode logic and the pipeline register stay in decode_stage.

Test Plan:
- Reset, then instr_valid_i=0 → all outputs 0 for 3 cycles; illegal_o=0.
- Write x5=0x0000_1234 through the writeback port; next cycle decode "add x3,x5,x5" (0x005281B3) → rs1_o=rs2_o=0x1234, alu_opcode_o=0, alu_src_o=0, rd_ptr_o=3, reg_we_o=1.
- Bypass:
  - wb_we_i=1, wb_ptr_i=6, wb_data_i=0xDEAD_BEEF in the same cycle as "addi x7,x6,-1" (0xFFF30393) → rs1_o=0xDEADBEEF, imm_o=0xFFFFFFFF.
  - The same with wb_ptr_i=0 → rs1_o=0.
- Loads/stores:
  - "lhu x1,4(x2)" → mem_re_o=1, mem_hb_o=01, mem_ul_o=1.
  - "sb x3,-8(x2)" → mem_we_o=1, reg_we_o=0, imm_o=0xFFFFFFF8.
  - Load with funct3=011 → bubble with illegal_o=1.
- Pipeline control:
  - Assert stall_i for 2 cycles while instr_i changes → outputs unchanged.
  - flush_i together with stall_i → bubble.
  - Write x0=0x55 → later read of x0 returns 0.
- Asserting rst_i after a valid ADD has been latched clears the outputs next cycle; registers written before reset still read back their values.
